// File: rtl/wb_upsize_bridge.sv
// Narrow (16/8-bit) Wishbone classic slave to registered 32-bit Wishbone master bridge.
// Optional one-entry read buffer enabled by defining WB_UPSIZE_READ_CACHE_EN.
module wb_upsize_bridge (
    input  logic        wb_lo_clk_i,
    input  logic        wb_lo_rst_n_i,
    input  logic [15:0] wb_lo_dat_i,
    output logic [15:0] wb_lo_dat_o,
    input  logic [31:0] wb_lo_adr_i,
    input  logic        wb_lo_cyc_i,
    input  logic        wb_lo_stb_i,
    input  logic        wb_lo_we_i,
    input  logic [1:0]  wb_lo_sel_i,
    output logic        wb_lo_ack_o,
    output logic        wb_lo_err_o,
    output logic        wb_lo_rty_o,
    output logic        wb_hi_clk_o,
    output logic        wb_hi_rst_o,
    output logic [31:0] wb_hi_dat_o,
    input  logic [31:0] wb_hi_dat_i,
    output logic [31:0] wb_hi_adr_o,
    output logic        wb_hi_cyc_o,
    output logic        wb_hi_stb_o,
    output logic        wb_hi_we_o,
    output logic [3:0]  wb_hi_sel_o,
    input  logic        wb_hi_ack_i,
    input  logic        wb_hi_err_i,
    input  logic        wb_hi_rty_i,
    input  logic        lo_byte_if_i
);

    // state | meaning
    // IDLE  | waiting for a narrow request
    // BUSY  | hi cycle outstanding, outputs held
    // DONE  | one-cycle lo ack/err/rty pulse
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic        req_byte;
    logic [1:0]  req_lane;
    logic        req_go;
    logic        req_valid;
    logic        cache_hit;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic [31:0] cache_dat;

    assign wb_hi_clk_o = wb_lo_clk_i;
    assign wb_hi_rst_o = ~wb_lo_rst_n_i;

    function automatic logic [15:0] steer(input logic [31:0] w, input logic [1:0] lane,
                                          input logic byte_mode);
        logic [15:0] r;
        if (byte_mode) begin
            case (lane)
                2'd0:    r = {8'h00, w[7:0]};
                2'd1:    r = {8'h00, w[15:8]};
                2'd2:    r = {8'h00, w[23:16]};
                default: r = {8'h00, w[31:24]};
            endcase
        end else begin
            r = lane[1] ? w[31:16] : w[15:0];
        end
        return r;
    endfunction

    always_comb begin
        req_go    = wb_lo_cyc_i & wb_lo_stb_i;
        req_valid = lo_byte_if_i | (~wb_lo_adr_i[0] & (|wb_lo_sel_i));
        if (lo_byte_if_i) begin
            req_sel = 4'b0001 << wb_lo_adr_i[1:0];
            req_dat = {4{wb_lo_dat_i[7:0]}};
        end else begin
            req_sel = wb_lo_adr_i[1] ? {wb_lo_sel_i, 2'b00} : {2'b00, wb_lo_sel_i};
            req_dat = {2{wb_lo_dat_i}};
        end
`ifdef WB_UPSIZE_READ_CACHE_EN
        // reads always fetch the full word so the buffer can serve any lane later
        if (!wb_lo_we_i) req_sel = 4'b1111;
`endif
    end

`ifdef WB_UPSIZE_READ_CACHE_EN
    logic        cache_vld;
    logic [29:0] cache_tag;

    assign cache_hit = cache_vld & ~wb_lo_we_i & (cache_tag == wb_lo_adr_i[31:2]);

    always_ff @(posedge wb_lo_clk_i or negedge wb_lo_rst_n_i) begin
        if (!wb_lo_rst_n_i) begin
            cache_vld <= 1'b0;
            cache_tag <= '0;
            cache_dat <= '0;
        end else if (state == ST_IDLE && req_go && wb_lo_we_i) begin
            cache_vld <= 1'b0;
        end else if (state == ST_BUSY && wb_lo_cyc_i) begin
            if (wb_hi_err_i) begin
                cache_vld <= 1'b0;
            end else if (wb_hi_ack_i && !wb_hi_rty_i && !wb_hi_we_o) begin
                cache_vld <= 1'b1;
                cache_tag <= wb_hi_adr_o[31:2];
                cache_dat <= wb_hi_dat_i;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_dat = 32'h0;
`endif

    always_ff @(posedge wb_lo_clk_i or negedge wb_lo_rst_n_i) begin
        if (!wb_lo_rst_n_i) begin
            state       <= ST_IDLE;
            req_byte    <= 1'b0;
            req_lane    <= 2'd0;
            wb_hi_cyc_o <= 1'b0;
            wb_hi_stb_o <= 1'b0;
            wb_hi_we_o  <= 1'b0;
            wb_hi_sel_o <= 4'h0;
            wb_hi_adr_o <= 32'h0;
            wb_hi_dat_o <= 32'h0;
            wb_lo_ack_o <= 1'b0;
            wb_lo_err_o <= 1'b0;
            wb_lo_rty_o <= 1'b0;
            wb_lo_dat_o <= 16'h0;
        end else begin
            wb_lo_ack_o <= 1'b0;
            wb_lo_err_o <= 1'b0;
            wb_lo_rty_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_go) begin
                        req_byte <= lo_byte_if_i;
                        req_lane <= wb_lo_adr_i[1:0];
                        if (!req_valid) begin
                            wb_lo_err_o <= 1'b1;
                            state       <= ST_DONE;
                        end else if (cache_hit) begin
                            wb_lo_ack_o <= 1'b1;
                            wb_lo_dat_o <= steer(cache_dat, wb_lo_adr_i[1:0], lo_byte_if_i);
                            state       <= ST_DONE;
                        end else begin
                            wb_hi_cyc_o <= 1'b1;
                            wb_hi_stb_o <= 1'b1;
                            wb_hi_we_o  <= wb_lo_we_i;
                            wb_hi_sel_o <= req_sel;
                            wb_hi_adr_o <= {wb_lo_adr_i[31:2], 2'b00};
                            wb_hi_dat_o <= req_dat;
                            state       <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!wb_lo_cyc_i) begin
                        wb_hi_cyc_o <= 1'b0;
                        wb_hi_stb_o <= 1'b0;
                        wb_hi_we_o  <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (wb_hi_ack_i || wb_hi_err_i || wb_hi_rty_i) begin
                        wb_hi_cyc_o <= 1'b0;
                        wb_hi_stb_o <= 1'b0;
                        wb_hi_we_o  <= 1'b0;
                        state       <= ST_DONE;
                        if (wb_hi_err_i) begin
                            wb_lo_err_o <= 1'b1;
                        end else if (wb_hi_rty_i) begin
                            wb_lo_rty_o <= 1'b1;
                        end else begin
                            wb_lo_ack_o <= 1'b1;
                            if (!wb_hi_we_o) wb_lo_dat_o <= steer(wb_hi_dat_i, req_lane, req_byte);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
